// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: one-at-a-time command initiator for the registered ALU datapath.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake carrying cmd_op, cmd_a, cmd_b
//   alu_a, alu_b, alu_sel      operands and select driven to the ALU, held while in flight
//   alu_result, alu_carry      registered ALU output, sampled LATENCY+1 edges after accept
//   rsp_valid/rsp_ready        response handshake carrying rsp_data, rsp_carry, rsp_zero
//   op_count                   completed response handshakes, wraps silently
module alu_cmd_sequencer #(
    parameter int SIZE    = 8,
    parameter int N       = 3,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N-1:0]     cmd_op,
    input  logic [SIZE-1:0]  cmd_a,
    input  logic [SIZE-1:0]  cmd_b,
    output logic [SIZE-1:0]  alu_a,
    output logic [SIZE-1:0]  alu_b,
    output logic [N-1:0]     alu_sel,
    input  logic [SIZE-1:0]  alu_result,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [SIZE-1:0]  rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] op_count
);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SIZE-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [N-1:0]      alu_sel_q, alu_sel_d;
    logic [SIZE-1:0]   rsp_data_q, rsp_data_d;
    logic              rsp_carry_q, rsp_carry_d, rsp_zero_q, rsp_zero_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        op_count_d  = op_count_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                alu_a_d   = cmd_a;
                alu_b_d   = cmd_b;
                alu_sel_d = cmd_op;
                cnt_d     = CW'(LATENCY);
                state_d   = WAIT;
            end
            // The extra edge spent at count zero lets the ALU register settle
            // before its output is captured.
            WAIT: if (cnt_q == '0) begin
                rsp_data_d  = alu_result;
                rsp_carry_d = alu_carry;
                rsp_zero_d  = alu_result == '0;
                state_d     = RESP;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            RESP: if (rsp_ready) begin
                op_count_d = op_count_q + CNT_W'(1);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
            op_count_q  <= op_count_d;
        end
    end

    assign cmd_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;
    assign op_count  = op_count_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed and randomized checks of alu_cmd_sequencer against a registered ALU model.
module tb_alu_cmd_sequencer;
    localparam int SIZE = 8;
    localparam int N    = 3;
    localparam int LAT  = 1;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [N-1:0]    cmd_op = '0;
    logic [SIZE-1:0] cmd_a = '0, cmd_b = '0;
    logic            cmd_ready, rsp_valid, rsp_carry, rsp_zero, alu_carry;
    logic [SIZE-1:0] alu_a, alu_b, alu_result, rsp_data;
    logic [N-1:0]    alu_sel;
    logic [CW-1:0]   op_count;

    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer #(.SIZE(SIZE), .N(N), .LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Result in the low SIZE bits, carry/borrow in the top bit.
    function automatic logic [SIZE:0] alu_f(logic [N-1:0] op, logic [SIZE-1:0] a, logic [SIZE-1:0] b);
        case (op)
            3'd0: return {1'b0, a};
            3'd1: return {1'b0, ~a};
            3'd2: return {1'b0, a} + {1'b0, b};
            3'd3: return {1'b0, a} - {1'b0, b};
            3'd4: return {1'b0, a | b};
            3'd5: return {1'b0, a & b};
            3'd6: return {{SIZE{1'b0}}, $signed(a) < $signed(b)};
            default: return '0;
        endcase
    endfunction

    // Registered ALU with LAT pipeline stages.
    logic [SIZE:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= alu_f(alu_sel, alu_a, alu_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign {alu_carry, alu_result} = pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [N-1:0] op, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         input logic [SIZE-1:0] exp_d, input logic exp_c);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        tick();
        cmd_valid = 1'b0;
        check("op_sel", 32'(alu_sel), 32'(op));
        check("op_a", 32'(alu_a), 32'(a));
        check("op_b", 32'(alu_b), 32'(b));
        repeat (LAT) tick();
        check("op_early_valid", 32'(rsp_valid), 0);
        tick();
        check("op_valid", 32'(rsp_valid), 1);
        check("op_data", 32'(rsp_data), 32'(exp_d));
        check("op_carry", 32'(rsp_carry), 32'(exp_c));
        check("op_zero", 32'(rsp_zero), 32'(exp_d == '0));
        tick();
        check("op_done_valid", 32'(rsp_valid), 0);
        check("op_done_ready", 32'(cmd_ready), 1);
    endtask

    logic [SIZE-1:0] sweep_exp [8] = '{8'hA5, 8'h5A, 8'hE1, 8'h69, 8'hBD, 8'h24, 8'h01, 8'h00};
    logic            sweep_c   [8] = '{0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        bit            busy;
        int            age;
        logic [SIZE:0] exp;
        logic [SIZE-1:0] ea, eb;
        logic [N-1:0]  eop;
        logic [CW-1:0] cnt;

        // Reset with random inputs toggling
        rst_n = 1'b0;
        repeat (4) begin
            cmd_valid = 1'($urandom); cmd_op = N'($urandom); cmd_a = SIZE'($urandom);
            cmd_b = SIZE'($urandom); rsp_ready = 1'($urandom);
            tick();
            check("rst_ready", 32'(cmd_ready), 1);
            check("rst_valid", 32'(rsp_valid), 0);
            check("rst_alu", {alu_a, alu_b, 5'(alu_sel)}, 0);
            check("rst_rsp", {rsp_data, rsp_carry, rsp_zero}, 0);
            check("rst_cnt", 32'(op_count), 0);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(cmd_ready), 1);

        // ADD 0x7F + 0x01
        do_op(3'd2, 8'h7F, 8'h01, 8'h80, 1'b0);
        check("add_count", 32'(op_count), 1);

        // SUB with back-pressure and a competing command
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 8'h05; cmd_b = 8'h07;
        tick();
        cmd_valid = 1'b0;
        repeat (LAT + 1) tick();
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 8'h0F; cmd_b = 8'hF0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_data", 32'(rsp_data), 32'h FE);
            check("bp_carry", 32'(rsp_carry), 1);
            check("bp_ready", 32'(cmd_ready), 0);
            check("bp_sel", 32'(alu_sel), 3);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_hs_valid", 32'(rsp_valid), 0);
        check("bp_hs_ready", 32'(cmd_ready), 1);
        check("bp_hs_sel", 32'(alu_sel), 3);
        check("bp_count", 32'(op_count), 2);
        tick();
        cmd_valid = 1'b0;
        check("bp2_sel", 32'(alu_sel), 4);
        check("bp2_a", 32'(alu_a), 32'h0F);
        repeat (LAT + 1) tick();
        check("bp2_data", 32'(rsp_data), 32'hFF);
        tick();
        check("bp2_count", 32'(op_count), 3);

        // Opcode sweep
        for (int i = 0; i < 8; i++) do_op(N'(i), 8'hA5, 8'h3C, sweep_exp[i], sweep_c[i]);
        check("sweep_count", 32'(op_count), 11);

        // Reset during WAIT
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 8'h10; cmd_b = 8'h20;
        tick();
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_alu", {alu_a, alu_b, 5'(alu_sel)}, 0);
        check("mid_cnt", 32'(op_count), 0);
        tick();
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            check("mid_no_rsp", 32'(rsp_valid), 0);
            check("mid_ready", 32'(cmd_ready), 1);
        end
        check("mid_cnt_after", 32'(op_count), 0);

        // Counter wrap
        for (int i = 1; i <= 17; i++) begin
            do_op(3'd0, 8'(i), 8'h00, 8'(i), 1'b0);
            if (i == 16) check("wrap16", 32'(op_count), 0);
        end
        check("wrap17", 32'(op_count), 1);

        // Randomized traffic against the transaction-level model
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        busy = 0; age = 0; cnt = '0; exp = '0; ea = '0; eb = '0; eop = '0;
        for (int c = 0; c < 3000; c++) begin
            check("rnd_ready", 32'(cmd_ready), 32'(!busy));
            check("rnd_valid", 32'(rsp_valid), 32'(busy && age > LAT));
            check("rnd_count", 32'(op_count), 32'(cnt));
            if (busy) check("rnd_alu", {alu_a, alu_b, 5'(alu_sel)}, {ea, eb, 5'(eop)});
            if (busy && age > LAT) begin
                check("rnd_data", 32'(rsp_data), 32'(exp[SIZE-1:0]));
                check("rnd_carry", 32'(rsp_carry), 32'(exp[SIZE]));
                check("rnd_zero", 32'(rsp_zero), 32'(exp[SIZE-1:0] == '0));
            end
            cmd_valid = 1'($urandom); cmd_op = N'($urandom); cmd_a = SIZE'($urandom);
            cmd_b = SIZE'($urandom); rsp_ready = ($urandom % 3) != 0;
            if (!busy && cmd_valid) begin
                busy = 1; age = 0;
                exp = alu_f(cmd_op, cmd_a, cmd_b);
                ea = cmd_a; eb = cmd_b; eop = cmd_op;
            end else if (busy && age > LAT && rsp_ready) begin
                busy = 0; cnt = cnt + 1'b1;
            end else if (busy) begin
                age++;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
